// File: rtl/pwm_bank.sv
// Multi-channel PWM/tone generator on an Avalon-MM slave port.
// Each channel has shadowed period/duty, output inversion and a finite burst mode with a done IRQ.
module pwm_bank #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_chipselect,
    input  logic              avs_write,
    input  logic              avs_read,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    localparam int unsigned CH_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    logic [CH_W-1:0]   ch_sel;
    logic [1:0]        reg_sel;
    logic              wr_en;
    logic [NUM_CH-1:0] ch_hit, period_wr, duty_wr, ctrl_wr, status_wr;
    logic [31:0]       rd_data;
    logic              unused_wdata;

    logic [CNT_W-1:0]  period_q    [NUM_CH];
    logic [CNT_W-1:0]  duty_q      [NUM_CH];
    logic [CNT_W-1:0]  sh_period_q [NUM_CH];
    logic [CNT_W-1:0]  sh_duty_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_q       [NUM_CH];
    logic [7:0]        burst_q     [NUM_CH];
    logic [7:0]        burst_left_q[NUM_CH];
    logic [NUM_CH-1:0] en_q, inv_q, irq_en_q, done_q;
    state_e            state_q     [NUM_CH];
    state_e            state_d     [NUM_CH];
    logic [NUM_CH-1:0] start, stop, wrap, finish, raw;

    assign reg_sel      = avs_address[1:0];
    assign wr_en        = avs_chipselect & avs_write;
    assign unused_wdata = ^avs_writedata;

    if (ADDR_W > 2) begin : g_ch_addr
        assign ch_sel = avs_address[ADDR_W-1:2];
    end else begin : g_ch_single
        assign ch_sel = '0;
    end

    // Channel indices with no matching channel never hit, so their writes drop and reads return 0.
    always_comb begin
        ch_hit    = '0;
        period_wr = '0;
        duty_wr   = '0;
        ctrl_wr   = '0;
        status_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_hit[i]    = (ch_sel == CH_W'(i));
            period_wr[i] = wr_en && ch_hit[i] && (reg_sel == 2'd0);
            duty_wr[i]   = wr_en && ch_hit[i] && (reg_sel == 2'd1);
            ctrl_wr[i]   = wr_en && ch_hit[i] && (reg_sel == 2'd2);
            status_wr[i] = wr_en && ch_hit[i] && (reg_sel == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= StIdle;
        end else begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
        end
    end

    // A zero shadow period never wraps, so such a burst can never finish.
    always_comb begin
        start  = '0;
        stop   = '0;
        wrap   = '0;
        finish = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            start[i]  = (state_q[i] == StIdle) && ctrl_wr[i] && avs_writedata[0];
            stop[i]   = (state_q[i] == StRun) && ctrl_wr[i] && !avs_writedata[0];
            wrap[i]   = (state_q[i] == StRun) && (sh_period_q[i] != '0) &&
                        (cnt_q[i] == sh_period_q[i]);
            finish[i] = wrap[i] && !stop[i] && (burst_left_q[i] == 8'd1);
            state_d[i] = state_q[i];
            unique case (state_q[i])
                StIdle:  if (start[i]) state_d[i] = StRun;
                StRun:   if (stop[i] || finish[i]) state_d[i] = StIdle;
                default: state_d[i] = StIdle;
            endcase
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            raw[i] = (state_q[i] == StRun) && (sh_period_q[i] != '0) &&
                     (cnt_q[i] < sh_duty_q[i]);
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_hit[i]) begin
                case (reg_sel)
                    2'd0: rd_data[CNT_W-1:0] = period_q[i];
                    2'd1: rd_data[CNT_W-1:0] = duty_q[i];
                    2'd2: rd_data = {16'd0, burst_q[i], 5'd0, irq_en_q[i], inv_q[i], en_q[i]};
                    default: rd_data = {30'd0, state_q[i] == StRun, done_q[i]};
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
            pwm_out      <= '0;
            irq          <= 1'b0;
            en_q         <= '0;
            inv_q        <= '0;
            irq_en_q     <= '0;
            done_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i]     <= '0;
                duty_q[i]       <= '0;
                sh_period_q[i]  <= '0;
                sh_duty_q[i]    <= '0;
                cnt_q[i]        <= '0;
                burst_q[i]      <= '0;
                burst_left_q[i] <= '0;
            end
        end else begin
            if (avs_chipselect && avs_read) avs_readdata <= rd_data;
            pwm_out <= raw ^ inv_q;
            irq     <= |(done_q & irq_en_q);
            for (int i = 0; i < NUM_CH; i++) begin
                if (period_wr[i]) period_q[i] <= avs_writedata[CNT_W-1:0];
                if (duty_wr[i])   duty_q[i]   <= avs_writedata[CNT_W-1:0];
                if (ctrl_wr[i]) begin
                    en_q[i]     <= avs_writedata[0];
                    inv_q[i]    <= avs_writedata[1];
                    irq_en_q[i] <= avs_writedata[2];
                    burst_q[i]  <= avs_writedata[15:8];
                end
                if (finish[i]) en_q[i] <= 1'b0;
                // Hardware set beats a same-edge clear.
                if (status_wr[i] && avs_writedata[0]) done_q[i] <= 1'b0;
                if (finish[i]) done_q[i] <= 1'b1;

                if (start[i]) begin
                    sh_period_q[i]  <= period_q[i];
                    sh_duty_q[i]    <= duty_q[i];
                    burst_left_q[i] <= avs_writedata[15:8];
                    cnt_q[i]        <= '0;
                end else if (state_q[i] == StRun) begin
                    if (stop[i] || (sh_period_q[i] == '0)) begin
                        cnt_q[i] <= '0;
                    end else if (wrap[i]) begin
                        cnt_q[i]       <= '0;
                        sh_period_q[i] <= period_q[i];
                        sh_duty_q[i]   <= duty_q[i];
                        if (burst_left_q[i] != 8'd0) burst_left_q[i] <= burst_left_q[i] - 8'd1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: directed and randomized channel setups compared against
// a waveform model derived from period/duty/burst arithmetic.
module tb_pwm_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_chipselect;
    logic              avs_write;
    logic              avs_read;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic [NUM_CH-1:0] pwm_out;
    logic              irq;

    pwm_bank #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_chipselect(avs_chipselect),
        .avs_write     (avs_write),
        .avs_read      (avs_read),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .pwm_out       (pwm_out),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    logic [NUM_CH-1:0] hist [0:8191];

    // Every clock edge is numbered; pwm_out just after edge n is logged in hist[n].
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        hist[cyc] = pwm_out;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        avs_address    = ADDR_W'((ch << 2) | r);
        avs_writedata  = d;
        avs_chipselect = 1'b1;
        avs_write      = 1'b1;
        tick();
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] d);
        avs_address    = ADDR_W'((ch << 2) | r);
        avs_chipselect = 1'b1;
        avs_read       = 1'b1;
        tick();
        avs_chipselect = 1'b0;
        avs_read       = 1'b0;
        d = avs_readdata;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // k = edges since the enabling write. Cycle j = k-1 of the run lies in period j/(p+1)
    // at phase j%(p+1); periods from index sw onward use duty d2.
    function automatic bit model_pwm(int k, int p, int d1, int d2, int sw, int n, bit inv);
        int j;
        int d;
        if (k < 1 || p == 0) return inv;
        j = k - 1;
        if (n != 0 && j >= n * (p + 1)) return inv;
        d = ((j / (p + 1)) >= sw) ? d2 : d1;
        return ((j % (p + 1)) < d) ^ inv;
    endfunction

    task automatic check_wave(input string tag, input int ch, input int s, input int last,
                              input int p, input int d1, input int d2, input int sw,
                              input int n, input bit inv);
        logic [127:0] o;
        logic [127:0] e;
        o = '0;
        e = '0;
        for (int c = s + 1; c <= last && c - s - 1 < 128; c++) begin
            o[c-s-1] = hist[c][ch];
            e[c-s-1] = model_pwm(c - s, p, d1, d2, sw, n, inv);
        end
        chk(tag, o, e);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    logic [31:0] d;
    int s, s0, s1, s3, target;
    int p [NUM_CH];
    int du [NUM_CH];
    int n [NUM_CH];
    int iv [NUM_CH];
    int st [NUM_CH];

    initial begin
        reset_n        = 1'b0;
        avs_address    = '0;
        avs_chipselect = 1'b0;
        avs_write      = 1'b0;
        avs_read       = 1'b0;
        avs_writedata  = '0;
        tick();
        tick();
        chk("reset_pwm", pwm_out, 0);
        chk("reset_irq", irq, 0);
        chk("reset_rdata", avs_readdata, 0);
        reset_n = 1'b1;
        tick();

        // Continuous mode, 3 high / 7 low.
        wr(0, 0, 9);
        wr(0, 1, 3);
        wr(0, 2, 32'h1);
        s = cyc;
        repeat (5) tick();
        rd(0, 3, d);
        chk("cont_status", d, 32'h2);
        repeat (30) tick();
        check_wave("cont_wave", 0, s, cyc, 9, 3, 3, 0, 0, 0);

        wr(0, 2, 32'h0);
        tick();
        chk("stop_idle", pwm_out[0], 0);
        rd(0, 3, d);
        chk("stop_status", d, 32'h0);

        // Duty rewritten at a random point in the first period takes effect from the second.
        wr(0, 2, 32'h1);
        s = cyc;
        repeat ($urandom_range(1, 7)) tick();
        wr(0, 1, 7);
        while (cyc < s + 42) tick();
        check_wave("shadow_wave", 0, s, cyc, 9, 3, 7, 1, 0, 0);

        // Burst of 3 with interrupt on channel 2.
        wr(2, 0, 4);
        wr(2, 1, 2);
        wr(2, 2, 32'h0305);
        s = cyc;
        repeat (22) tick();
        check_wave("burst_wave", 2, s, cyc, 4, 2, 2, 0, 3, 0);
        rd(2, 3, d);
        chk("burst_status", d, 32'h1);
        chk("burst_irq", irq, 1);
        rd(2, 2, d);
        chk("burst_ctrl", d, 32'h0304);
        wr(2, 3, 32'h1);
        tick();
        chk("w1c_irq", irq, 0);
        rd(2, 3, d);
        chk("w1c_status", d, 32'h0);

        // Asynchronous reset while channels run and irq is set.
        wr(2, 2, 32'h0105);
        repeat (10) tick();
        chk("pre_reset_irq", irq, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_rst_pwm", pwm_out, 0);
        chk("async_rst_irq", irq, 0);
        tick();
        reset_n = 1'b1;
        tick();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd(c, r, d);
                chk($sformatf("rst_reg_ch%0d_r%0d", c, r), d, 32'h0);
            end
        end

        // Edge values.
        wr(1, 0, 9);
        wr(1, 1, 12);
        wr(1, 2, 32'h1);
        s1 = cyc;
        wr(3, 2, 32'h2);
        tick();
        chk("idle_inv", pwm_out[3], 1);
        wr(3, 0, 5);
        wr(3, 2, 32'h3);
        s3 = cyc;
        wr(0, 0, 0);
        wr(0, 1, 3);
        wr(0, 2, 32'h0105);
        s0 = cyc;
        repeat (30) tick();
        check_wave("duty_gt_period", 1, s1, cyc, 9, 12, 12, 0, 0, 0);
        check_wave("inv_duty0", 3, s3, cyc, 5, 0, 0, 0, 0, 1);
        check_wave("period0", 0, s0, cyc, 0, 3, 3, 0, 1, 0);
        rd(0, 3, d);
        chk("period0_status", d, 32'h2);
        chk("period0_irq", irq, 0);

        // Randomized concurrent channels; channel 3 gets a W1C on its DONE edge.
        for (int round = 0; round < 3; round++) begin
            do_reset();
            for (int i = 0; i < NUM_CH; i++) begin
                p[i]  = $urandom_range(1, 8);
                du[i] = $urandom_range(0, 10);
                n[i]  = $urandom_range(0, 3);
                iv[i] = $urandom_range(0, 1);
            end
            n[3] = $urandom_range(1, 3);
            for (int i = 0; i < NUM_CH; i++) begin
                wr(i, 0, 32'(p[i]));
                wr(i, 1, 32'(du[i]));
            end
            for (int i = 0; i < NUM_CH; i++) begin
                wr(i, 2, 32'((n[i] << 8) | ((i == 3) ? 4 : 0) | (iv[i] << 1) | 1));
                st[i] = cyc;
            end
            target = st[3] + n[3] * (p[3] + 1);
            while (cyc < target - 1) tick();
            wr(3, 3, 32'h1);
            while (cyc < st[0] + 100) tick();
            for (int i = 0; i < NUM_CH; i++) begin
                check_wave($sformatf("rand%0d_ch%0d", round, i), i, st[i], cyc,
                           p[i], du[i], du[i], 0, n[i], iv[i][0]);
            end
            rd(3, 3, d);
            chk($sformatf("rand%0d_same_edge_done", round), d, 32'h1);
            chk($sformatf("rand%0d_irq", round), irq, 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
